load_axi_rd_master: RTL and testbench

- AXI4 read master between the load buffer (upstream request/response consumer) and the DRAM AXI slave.
- Accepts one read request at a time from the load buffer and drives the AR channel.
- Receives R beats, checks them against the request, buffers them in a small FIFO, and presents them to the load buffer as the ctrl_sram_r* stream with a single-cycle-accept handshake.

---
 rtl/lsu_axi_pkg.sv | 17 +
 rtl/rd_beat_fifo.sv | 40 ++++
 rtl/load_axi_rd_master.sv | 144 ++++++++++++++
 tb/tb_load_axi_rd_master.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_pkg.sv
// lsu_axi_pkg: shared AXI encodings, read-master FSM states and the buffered R-beat layout.
package lsu_axi_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam int BEAT_W = 8 + 32 + 2 + 1;
    typedef enum logic [2:0] {RD_IDLE, RD_AR, RD_RD, RD_DROP, RD_DRAIN} rd_state_t;
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rd_beat_t;
endpackage

// File: rtl/rd_beat_fifo.sv
// rd_beat_fifo: synchronous FIFO with registered count; pushes are refused while full.
module rd_beat_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/load_axi_rd_master.sv
// load_axi_rd_master: single-outstanding AXI4 read master feeding R beats to the load buffer.
// Optional watchdog enabled by LOAD_AXI_RD_TIMEOUT_EN.
module load_axi_rd_master #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  load_axi_arid,
    input  logic [11:0] load_axi_arraddr,
    input  logic [7:0]  load_axi_arlen,
    input  logic [2:0]  load_axi_arsize,
    input  logic [1:0]  load_axi_arburst,
    input  logic        load_axi_arvld,
    input  logic        load_axi_rrdy,
    output logic        ctrl_dram_arrdy,
    output logic [7:0]  ctrl_sram_rid,
    output logic [31:0] ctrl_sram_rdata,
    output logic [1:0]  ctrl_sram_rresp,
    output logic        ctrl_sram_rlast,
    output logic        ctrl_sram_rvld,
    output logic [7:0]  m_axi_arid,
    output logic [11:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [7:0]  m_axi_rid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        rd_busy
);
    import lsu_axi_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    rd_state_t      state, state_nxt;
    logic [7:0]     id_q, len_q, beat_cnt;
    logic [11:0]    addr_q;
    logic [2:0]     size_q;
    logic [1:0]     burst_q;
    logic           push, pop, full, empty, ar_hs, r_hs, fire;
    logic [CW-1:0]  count;
    rd_beat_t       din, head;

    rd_beat_fifo #(.W(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
        .dout(head), .full(full), .empty(empty), .count(count)
    );

    assign {ctrl_sram_rid, ctrl_sram_rdata, ctrl_sram_rresp, ctrl_sram_rlast} = head;
    assign ctrl_sram_rvld = !empty;
    assign pop            = ctrl_sram_rvld && load_axi_rrdy;
    assign rd_busy        = state != RD_IDLE;
    assign ar_hs          = m_axi_arvalid && m_axi_arready;
    assign r_hs           = m_axi_rvalid && m_axi_rready;
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} =
           {id_q, addr_q, len_q, size_q, burst_q};

`ifdef LOAD_AXI_RD_TIMEOUT_EN
    logic [15:0] wd;
    // A beat arriving in the firing cycle counts as progress, so it wins over the timeout.
    assign fire = (state == RD_AR || (state == RD_RD && !m_axi_rvalid)) &&
                  wd >= 16'(TIMEOUT_CYC) && !full;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd <= '0;
        else if (!(state == RD_AR || state == RD_RD) || ar_hs || r_hs || fire) wd <= '0;
        else if (wd != 16'hffff) wd <= wd + 1'b1;
    end
`else
    assign fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        ctrl_dram_arrdy = 1'b0;
        m_axi_arvalid   = 1'b0;
        m_axi_rready    = 1'b0;
        push            = 1'b0;
        din = {m_axi_rid, m_axi_rdata, (m_axi_rid != id_q) ? AXI_RESP_SLVERR : m_axi_rresp, m_axi_rlast};
        case (state)
            RD_IDLE: begin
                ctrl_dram_arrdy = 1'b1;
                if (load_axi_arvld) state_nxt = RD_AR;
            end
            RD_AR: begin
                m_axi_arvalid = !fire;
                if (m_axi_arready && !fire) state_nxt = RD_RD;
            end
            RD_RD: begin
                m_axi_rready = !full;
                if (m_axi_rvalid && !full) begin
                    push = 1'b1;
                    // Early or missing rlast both terminate the burst with an error beat.
                    if (beat_cnt == len_q && m_axi_rlast) state_nxt = RD_DRAIN;
                    else if (beat_cnt == len_q || m_axi_rlast) begin
                        din.resp  = AXI_RESP_SLVERR;
                        din.last  = 1'b1;
                        state_nxt = m_axi_rlast ? RD_DRAIN : RD_DROP;
                    end
                end
            end
            RD_DROP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && m_axi_rlast) state_nxt = RD_DRAIN;
            end
            RD_DRAIN: if (empty || (count == CW'(1) && pop)) state_nxt = RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
        if (fire) begin
            push      = 1'b1;
            din       = {id_q, 32'h0, AXI_RESP_DECERR, 1'b1};
            state_nxt = RD_DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == RD_IDLE && load_axi_arvld) begin
                id_q    <= load_axi_arid;
                addr_q  <= load_axi_arraddr;
                len_q   <= load_axi_arlen;
                size_q  <= load_axi_arsize;
                burst_q <= (load_axi_arburst == AXI_BURST_FIXED) ? AXI_BURST_INCR : load_axi_arburst;
            end
            if (state == RD_AR && ar_hs) beat_cnt <= '0;
            else if (state == RD_RD && r_hs) beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_load_axi_rd_master.sv
// tb_load_axi_rd_master: scoreboard bench; a list-level model predicts the beats seen by the load buffer.
module tb_load_axi_rd_master;
    logic        clk = 0, rst_n = 0;
    logic [7:0]  load_axi_arid = 0, load_axi_arlen = 0;
    logic [11:0] load_axi_arraddr = 0;
    logic [2:0]  load_axi_arsize = 0;
    logic [1:0]  load_axi_arburst = 0;
    logic        load_axi_arvld = 0, load_axi_rrdy = 0;
    logic        ctrl_dram_arrdy, ctrl_sram_rlast, ctrl_sram_rvld, m_axi_arvalid, m_axi_rready, rd_busy;
    logic [7:0]  ctrl_sram_rid, m_axi_arid, m_axi_arlen;
    logic [31:0] ctrl_sram_rdata;
    logic [1:0]  ctrl_sram_rresp, m_axi_arburst;
    logic [11:0] m_axi_araddr;
    logic [2:0]  m_axi_arsize;
    logic        m_axi_arready = 0, m_axi_rlast = 0, m_axi_rvalid = 0;
    logic [7:0]  m_axi_rid = 0;
    logic [31:0] m_axi_rdata = 0;
    logic [1:0]  m_axi_rresp = 0;

    load_axi_rd_master dut (
        .clk(clk), .rst_n(rst_n),
        .load_axi_arid(load_axi_arid), .load_axi_arraddr(load_axi_arraddr),
        .load_axi_arlen(load_axi_arlen), .load_axi_arsize(load_axi_arsize),
        .load_axi_arburst(load_axi_arburst), .load_axi_arvld(load_axi_arvld),
        .load_axi_rrdy(load_axi_rrdy), .ctrl_dram_arrdy(ctrl_dram_arrdy),
        .ctrl_sram_rid(ctrl_sram_rid), .ctrl_sram_rdata(ctrl_sram_rdata),
        .ctrl_sram_rresp(ctrl_sram_rresp), .ctrl_sram_rlast(ctrl_sram_rlast),
        .ctrl_sram_rvld(ctrl_sram_rvld), .m_axi_arid(m_axi_arid),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } bt_t;

    bt_t exp_q[$];
    bt_t sb[$];
    int  errs = 0, checks = 0;
    bit  hold = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 load_axi_rrdy = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        bt_t e;
        if (rst_n && ctrl_sram_rvld && load_axi_rrdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL beat: got unexpected %0h expected none",
                         {ctrl_sram_rid, ctrl_sram_rdata, ctrl_sram_rresp, ctrl_sram_rlast});
            end else begin
                e = exp_q.pop_front();
                chk("beat", {ctrl_sram_rid, ctrl_sram_rdata, ctrl_sram_rresp, ctrl_sram_rlast}, e);
            end
        end
    end

    // What the load buffer must see: beats up to the first rlast or the (len+1)th beat,
    // whichever comes first; any irregular ending becomes SLVERR+last.
    task automatic model(input logic [7:0] id, input logic [7:0] len);
        bt_t e;
        for (int i = 0; i < sb.size(); i++) begin
            e = sb[i];
            if (e.id != id) e.resp = 2'b10;
            if (i == int'(len) || sb[i].last) begin
                if (!(i == int'(len) && sb[i].last)) e.resp = 2'b10;
                e.last = 1'b1;
                exp_q.push_back(e);
                break;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic txn(input logic [7:0] id, input logic [11:0] addr, input logic [7:0] len,
                       input int n, input int bad, input int ard, input bit bp, input int rst_at);
        bt_t b;
        int t;
        logic [2:0] sz = 3'($urandom);
        logic [1:0] bu = 2'($urandom_range(0, 2));
        sb.delete();
        for (int i = 0; i < n; i++) begin
            b.id   = (i == bad) ? id + 8'd1 : id;
            b.data = $urandom;
            b.resp = 2'($urandom_range(0, 1));
            b.last = (i == n - 1);
            sb.push_back(b);
        end
        model(id, len);
        @(negedge clk);
        chk("arrdy_idle", ctrl_dram_arrdy, 1);
        load_axi_arid = id; load_axi_arraddr = addr; load_axi_arlen = len;
        load_axi_arsize = sz; load_axi_arburst = bu; load_axi_arvld = 1;
        @(posedge clk);
        #1 load_axi_arvld = 0;
        t = 0;
        while (!m_axi_arvalid && t < 20) begin @(negedge clk); t++; end
        chk("arvalid", m_axi_arvalid, 1);
        repeat (ard) @(negedge clk);
        chk("ar_payload", {m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst},
            {1'b1, id, addr, len, sz, (bu == 2'b00) ? 2'b01 : bu});
        m_axi_arready = 1;
        @(posedge clk);
        #1 m_axi_arready = 0;
        chk("arvalid_drop", m_axi_arvalid, 0);
        for (int i = 0; i < sb.size(); i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            @(negedge clk);
            {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = sb[i];
            m_axi_rvalid = 1;
            if (bp && i == 4) begin
                repeat (3) begin
                    chk("bp_rready", {m_axi_rready, ctrl_sram_rvld}, 2'b01);
                    @(negedge clk);
                end
                hold = 0;
            end
            t = 0;
            while (!m_axi_rready && t < 50) begin @(negedge clk); t++; end
            if (t == 50) chk("rready_timeout", m_axi_rready, 1);
            @(posedge clk);
            #1 m_axi_rvalid = 0;
            if (i == rst_at) begin
                rst_n = 0;
                #1;
                chk("rst_ctrl", {ctrl_sram_rvld, ctrl_sram_rid, ctrl_sram_rdata, ctrl_sram_rresp, ctrl_sram_rlast}, 0);
                chk("rst_axi", {m_axi_arvalid, m_axi_rready, rd_busy, m_axi_arid, m_axi_araddr, m_axi_arlen,
                                m_axi_arsize, m_axi_arburst}, 0);
                exp_q.delete();
                break;
            end
        end
        if (rst_at >= 0) begin
            @(negedge clk);
            rst_n = 1;
        end else begin
            t = 0;
            while ((exp_q.size() != 0 || rd_busy) && t < 300) begin @(negedge clk); t++; end
            chk("done", {exp_q.size() != 0, rd_busy}, 0);
        end
    endtask

    initial begin
        int len, kind, n, bad;
        repeat (3) @(negedge clk);
        chk("reset_in", {m_axi_arvalid, m_axi_rready, ctrl_sram_rvld, rd_busy, ctrl_dram_arrdy}, 5'b00001);
        rst_n = 1;
        @(negedge clk);
        chk("reset_out", {m_axi_arvalid, m_axi_rready, ctrl_sram_rvld, rd_busy, ctrl_dram_arrdy}, 5'b00001);
        txn(8'h05, 12'h100, 8'd3, 4, -1, 2, 0, -1);
        hold = 1;
        repeat (2) @(negedge clk);
        txn(8'h21, 12'h240, 8'd7, 8, -1, 1, 1, -1);
        txn(8'h05, 12'h300, 8'd3, 4, 1, 0, 0, -1);
        txn(8'h33, 12'h010, 8'd3, 2, -1, 1, 0, -1);
        txn(8'h44, 12'h020, 8'd1, 4, -1, 0, 0, -1);
        txn(8'h55, 12'h0a0, 8'd3, 4, -1, 0, 0, 0);
        txn(8'h56, 12'h0b0, 8'd2, 3, -1, 1, 0, -1);
        for (int k = 0; k < 30; k++) begin
            len  = $urandom_range(0, 7);
            kind = $urandom_range(0, 3);
            n    = (kind == 2 && len > 0) ? $urandom_range(1, len) :
                   (kind == 3) ? len + 1 + $urandom_range(1, 3) : len + 1;
            bad  = (kind == 1) ? $urandom_range(0, len) : -1;
            txn(8'($urandom), 12'($urandom), 8'(len), n, bad, $urandom_range(0, 3), 0, -1);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
